sw_debounce: RTL and testbench

- Conditioning stage directly upstream of the switch PIO (Avalon input port).
- Synchronises the raw board slide-switch bus into the `clk` domain and debounces each bit independently.
- Drives the clean bus into the PIO `in_port`.
- Provides per-bit one-cycle rise/fall pulses for the clock-setting logic (set/adjust modes).

---
 rtl/sw_debounce.sv | 98 +++++++++
 tb/tb_sw_debounce.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// sw_debounce: two-flop synchroniser plus independent per-bit debounce counters with registered edge pulses.
// Optional feature: `define SW_DEBOUNCE_EDGE_LATCH_EN adds a sticky rise-capture register (edge_latch/edge_clr).
module sw_debounce #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
`ifdef SW_DEBOUNCE_EDGE_LATCH_EN
    input  logic [WIDTH-1:0] edge_clr,
    output logic [WIDTH-1:0] edge_latch,
`endif
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [WIDTH-1:0] clean_q, clean_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             changed_q, changed_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // The counter only runs while the synchronised level disagrees with the accepted one,
    // so any bounce back to the accepted level restarts the stability window.
    always_comb begin
        clean_d = clean_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != clean_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    clean_d[i] = s2_q[i];
                    rise_d[i]  = s2_q[i];
                    fall_d[i]  = ~s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
        changed_d = |(rise_d | fall_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q      <= '0;
            s2_q      <= '0;
            clean_q   <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q      <= sw_raw;
            s2_q      <= s1_q;
            clean_q   <= clean_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw_clean   = clean_q;
    assign sw_rise    = rise_q;
    assign sw_fall    = fall_q;
    assign sw_changed = changed_q;

`ifdef SW_DEBOUNCE_EDGE_LATCH_EN
    logic [WIDTH-1:0] latch_q;

    // A rise pulse arriving together with a clear still leaves the bit set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            latch_q <= '0;
        end else begin
            latch_q <= (latch_q & ~edge_clr) | rise_q;
        end
    end

    assign edge_latch = latch_q;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with DEBOUNCE_CYCLES=4: vector table plus hand-written reset and edge-latch sequences.
module tb_sw_debounce;

    localparam int W = 10;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] sw_raw = '0;
    logic [W-1:0] sw_clean;
    logic [W-1:0] sw_rise;
    logic [W-1:0] sw_fall;
    logic         sw_changed;
`ifdef SW_DEBOUNCE_EDGE_LATCH_EN
    logic [W-1:0] edge_clr = '0;
    logic [W-1:0] edge_latch;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] raw;
        logic [W-1:0] clean;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         chg;
    } vec_t;

    vec_t tbl[$];

    sw_debounce #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sw_raw    (sw_raw),
`ifdef SW_DEBOUNCE_EDGE_LATCH_EN
        .edge_clr  (edge_clr),
        .edge_latch(edge_latch),
`endif
        .sw_clean  (sw_clean),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall),
        .sw_changed(sw_changed)
    );

    always #5 clk = ~clk;

    task automatic v(input logic [W-1:0] raw, input logic [W-1:0] clean,
                     input logic [W-1:0] rise, input logic [W-1:0] fall, input logic chg);
        vec_t e;
        e.raw = raw; e.clean = clean; e.rise = rise; e.fall = fall; e.chg = chg;
        tbl.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic [W-1:0] raw);
        sw_raw = raw;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [W-1:0] clean,
                           input logic [W-1:0] rise, input logic [W-1:0] fall, input logic chg);
        chk({tag, " clean"},   32'(sw_clean),   32'(clean));
        chk({tag, " rise"},    32'(sw_rise),    32'(rise));
        chk({tag, " fall"},    32'(sw_fall),    32'(fall));
        chk({tag, " changed"}, 32'(sw_changed), 32'(chg));
    endtask

    initial begin
        // Power-up with all switches high: accepted at the 6th edge after release.
        repeat (5) v(10'h3FF, 10'h000, 10'h000, 10'h000, 1'b0);
        v(10'h3FF, 10'h3FF, 10'h3FF, 10'h000, 1'b1);
        repeat (2) v(10'h3FF, 10'h3FF, 10'h000, 10'h000, 1'b0);
        // Bit 3 falls then rises again.
        repeat (5) v(10'h3F7, 10'h3FF, 10'h000, 10'h000, 1'b0);
        v(10'h3F7, 10'h3F7, 10'h000, 10'h008, 1'b1);
        v(10'h3F7, 10'h3F7, 10'h000, 10'h000, 1'b0);
        repeat (5) v(10'h3FF, 10'h3F7, 10'h000, 10'h000, 1'b0);
        v(10'h3FF, 10'h3FF, 10'h008, 10'h000, 1'b1);
        v(10'h3FF, 10'h3FF, 10'h000, 10'h000, 1'b0);
        // Bit 1 low, then bit 1 up and bit 9 down together.
        repeat (5) v(10'h3FD, 10'h3FF, 10'h000, 10'h000, 1'b0);
        v(10'h3FD, 10'h3FD, 10'h000, 10'h002, 1'b1);
        v(10'h3FD, 10'h3FD, 10'h000, 10'h000, 1'b0);
        repeat (5) v(10'h1FF, 10'h3FD, 10'h000, 10'h000, 1'b0);
        v(10'h1FF, 10'h1FF, 10'h002, 10'h200, 1'b1);
        v(10'h1FF, 10'h1FF, 10'h000, 10'h000, 1'b0);
        // Bit 0 low, then bounce 3 high / 1 low, then a clean 6-cycle high.
        repeat (5) v(10'h1FE, 10'h1FF, 10'h000, 10'h000, 1'b0);
        v(10'h1FE, 10'h1FE, 10'h000, 10'h001, 1'b1);
        v(10'h1FE, 10'h1FE, 10'h000, 10'h000, 1'b0);
        repeat (3) begin
            repeat (3) v(10'h1FF, 10'h1FE, 10'h000, 10'h000, 1'b0);
            v(10'h1FE, 10'h1FE, 10'h000, 10'h000, 1'b0);
        end
        repeat (5) v(10'h1FF, 10'h1FE, 10'h000, 10'h000, 1'b0);
        v(10'h1FF, 10'h1FF, 10'h001, 10'h000, 1'b1);
        v(10'h1FF, 10'h1FF, 10'h000, 10'h000, 1'b0);

        // Reset held with switches high.
        sw_raw = 10'h3FF;
        repeat (3) @(posedge clk);
        #1;
        chk_out("in_reset", 10'h000, 10'h000, 10'h000, 1'b0);
        reset = 1'b0;

        for (int k = 0; k < tbl.size(); k++) begin
            step(tbl[k].raw);
            chk_out($sformatf("vec%0d", k), tbl[k].clean, tbl[k].rise, tbl[k].fall, tbl[k].chg);
        end

        // Reset while bit 3 is part way through its count.
        for (int k = 0; k < 4; k++) begin
            step(10'h1F7);
            chk_out($sformatf("midcnt%0d", k), 10'h1FF, 10'h000, 10'h000, 1'b0);
        end
        reset = 1'b1;
        #1;
        chk_out("async_rst", 10'h000, 10'h000, 10'h000, 1'b0);
        for (int k = 0; k < 2; k++) begin
            step(10'h1F7);
            chk_out($sformatf("rst_hold%0d", k), 10'h000, 10'h000, 10'h000, 1'b0);
        end
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(10'h1F7);
            chk_out($sformatf("post_rst%0d", k), 10'h000, 10'h000, 10'h000, 1'b0);
        end
        step(10'h1F7);
        chk_out("post_rst_acc", 10'h1F7, 10'h1F7, 10'h000, 1'b1);
        step(10'h1F7);
        chk_out("post_rst_end", 10'h1F7, 10'h000, 10'h000, 1'b0);

`ifdef SW_DEBOUNCE_EDGE_LATCH_EN
        chk("latch_after_rise", 32'(edge_latch), 32'h1F7);
        edge_clr = 10'h3FF;
        step(10'h1F7);
        edge_clr = '0;
        chk("latch_clr_all", 32'(edge_latch), 32'h000);
        repeat (6) step(10'h1D7);
        chk("b5_fall", 32'(sw_fall), 32'h020);
        repeat (6) step(10'h1F7);
        chk("b5_rise", 32'(sw_rise), 32'h020);
        step(10'h1F7);
        chk("latch_b5_set", 32'(edge_latch), 32'h020);
        repeat (6) step(10'h1D7);
        chk("latch_b5_hold", 32'(edge_latch), 32'h020);
        repeat (6) step(10'h1F7);
        chk("b5_rise2", 32'(sw_rise), 32'h020);
        edge_clr = 10'h020;
        step(10'h1F7);
        edge_clr = '0;
        chk("latch_set_wins", 32'(edge_latch), 32'h020);
        edge_clr = 10'h020;
        step(10'h1F7);
        edge_clr = '0;
        chk("latch_lone_clr", 32'(edge_latch), 32'h000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
